burst_rx_bridge: RTL and testbench

Store-and-forward burst bridge between the master agent's byte stream and the slave agent. It accepts a length header followed by that many data bytes, buffers the whole burst, then replays it to the slave side as one contiguous burst with a last-beat marker. It keeps the slave from ever seeing a partial burst, and it flags bad headers.

---
 rtl/burst_pkg.sv | 14 +
 rtl/burst_buf.sv | 25 ++
 rtl/burst_rx_bridge.sv | 98 +++++++++
 tb/tb_burst_rx_bridge.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/burst_pkg.sv
// Shared types and defaults for the burst bridge and the agents that talk to it.
package burst_pkg;

    localparam int BURST_DATA_W  = 8;
    localparam int BURST_MAX_LEN = 16;

    typedef enum logic [1:0] {S_HDR, S_DATA, S_SEND} burst_state_e;

    // Pointer width for a buffer of n entries; at least one bit so depth-1 buffers still index.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/burst_buf.sv
// Burst storage: one synchronous write port, one asynchronous read port, no reset on the array.
module burst_buf
    import burst_pkg::*;
#(
    parameter int DATA_W  = BURST_DATA_W,
    parameter int MAX_LEN = BURST_MAX_LEN,
    parameter int PW      = ptr_w(MAX_LEN)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [PW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [MAX_LEN];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/burst_rx_bridge.sv
// Store-and-forward bridge: header + L bytes in, one contiguous L-beat burst out with out_last.
module burst_rx_bridge
    import burst_pkg::*;
#(
    parameter int DATA_W  = BURST_DATA_W,
    parameter int MAX_LEN = BURST_MAX_LEN,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              len_err,
    output logic              busy,
    output logic [CNT_W-1:0]  burst_cnt
);

    localparam int PW = ptr_w(MAX_LEN);
    localparam logic [DATA_W:0] MAXL = (DATA_W+1)'(MAX_LEN);

    burst_state_e      state, state_nx;
    logic [PW-1:0]     wptr, rptr, lm1;
    logic              rdy_q, len_err_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] rdata;
    logic              in_hs, hdr_ok, wr_last, rd_last;

    assign in_hs   = in_valid && rdy_q;
    assign hdr_ok  = (in_data != '0) && ({1'b0, in_data} <= MAXL);
    assign wr_last = (wptr == lm1);
    assign rd_last = (rptr == lm1);

    always_comb begin
        state_nx = state;
        case (state)
            S_HDR:   if (in_hs && hdr_ok)    state_nx = S_DATA;
            S_DATA:  if (in_hs && wr_last)   state_nx = S_SEND;
            S_SEND:  if (out_ready && rd_last) state_nx = S_HDR;
            default: state_nx = S_HDR;
        endcase
    end

    // in_ready is a register so it reads 0 while reset is held and rises on the first free edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_HDR;
            rdy_q     <= 1'b0;
            wptr      <= '0;
            rptr      <= '0;
            lm1       <= '0;
            len_err_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state     <= state_nx;
            rdy_q     <= (state_nx != S_SEND);
            len_err_q <= (state == S_HDR) && in_hs && !hdr_ok;
            case (state)
                S_HDR: if (in_hs && hdr_ok) begin
                    lm1  <= PW'(in_data - DATA_W'(1));
                    wptr <= '0;
                end
                S_DATA: if (in_hs) begin
                    wptr <= wptr + 1'b1;
                    if (wr_last) rptr <= '0;
                end
                S_SEND: if (out_ready) begin
                    rptr <= rptr + 1'b1;
                    if (rd_last) cnt_q <= cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    burst_buf #(.DATA_W(DATA_W), .MAX_LEN(MAX_LEN), .PW(PW)) u_buf (
        .clk   (clk),
        .we    ((state == S_DATA) && in_hs),
        .waddr (wptr),
        .wdata (in_data),
        .raddr (rptr),
        .rdata (rdata)
    );

    // Gate the read port so stale or uninitialised buffer bytes never reach out_data.
    assign in_ready  = rdy_q;
    assign out_valid = (state == S_SEND);
    assign out_data  = (state == S_SEND) ? rdata : '0;
    assign out_last  = (state == S_SEND) && rd_last;
    assign len_err   = len_err_q;
    assign busy      = (state != S_HDR);
    assign burst_cnt = cnt_q;

endmodule

// File: tb/tb_burst_rx_bridge.sv
// Directed + randomized bench for burst_rx_bridge against a burst-level reference model.
module tb_burst_rx_bridge;

    localparam int DATA_W  = 8;
    localparam int MAX_LEN = 16;
    localparam int CNT_W   = 8;
    localparam int CNT_MOD = 1 << CNT_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid, in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid, out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last, len_err, busy;
    logic [CNT_W-1:0]  burst_cnt;

    int errs   = 0;
    int checks = 0;
    int exp_cnt = 0;
    bit tog = 1'b0;

    burst_rx_bridge #(.DATA_W(DATA_W), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .len_err   (len_err),
        .busy      (busy),
        .burst_cnt (burst_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_in_ready"},  32'(in_ready), 1);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_busy"},      32'(busy), 0);
        chk({tag, "_cnt"},       32'(burst_cnt), 32'(exp_cnt));
    endtask

    // One in-side beat; waits (bounded) for in_ready, checks nothing is being presented.
    task automatic put_beat(input logic [7:0] d, input string tag);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 50) begin tick; n++; end
        chk({tag, "_in_ready"},  32'(in_ready), 1);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        tick;
        in_valid = 1'b0;
    endtask

    // Consume the burst on the out side; mode 0 ready=1, 1 toggling from 0, 2 random.
    task automatic drain(input logic [7:0] q[$], input int mode, input string tag);
        int n = q.size();
        tog = 1'b0;
        for (int i = 0; i < n; i++) begin
            bit done = 1'b0;
            int guard = 0;
            while (!done && guard < 64) begin
                case (mode)
                    0:       out_ready = 1'b1;
                    1:       begin out_ready = tog; tog = ~tog; end
                    default: out_ready = 1'($urandom_range(0, 1));
                endcase
                chk({tag, "_out_valid"}, 32'(out_valid), 1);
                chk({tag, "_out_data"},  32'(out_data), 32'(q[i]));
                chk({tag, "_out_last"},  32'(out_last), (i == n - 1) ? 1 : 0);
                chk({tag, "_in_ready_send"}, 32'(in_ready), 0);
                if (out_ready) done = 1'b1;
                tick;
                guard++;
            end
            if (!done) chk({tag, "_drain_timeout"}, 0, 1);
        end
        out_ready = 1'b0;
        exp_cnt = (exp_cnt + 1) % CNT_MOD;
        chk_idle({tag, "_after"});
    endtask

    task automatic burst(input logic [7:0] q[$], input int mode, input string tag);
        put_beat(8'(q.size()), {tag, "_hdr"});
        chk({tag, "_busy_data"}, 32'(busy), 1);
        foreach (q[i]) put_beat(q[i], {tag, "_dat"});
        drain(q, mode, tag);
    endtask

    task automatic bad_hdr(input logic [7:0] h, input string tag);
        in_valid = 1'b1;
        in_data  = h;
        chk({tag, "_in_ready"}, 32'(in_ready), 1);
        tick;
        chk({tag, "_len_err"},   32'(len_err), 1);
        chk({tag, "_busy"},      32'(busy), 0);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
    endtask

    initial begin
        logic [7:0] q[$];
        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // reset values
        tick;
        tick;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_len_err", 32'(len_err), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cnt", 32'(burst_cnt), 0);
        reset = 1'b0;
        chk("rel_in_ready_low", 32'(in_ready), 0);
        tick;
        chk("rel_in_ready_high", 32'(in_ready), 1);

        // nominal
        q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        burst(q, 0, "nominal");

        // backpressure
        q = '{8'h10, 8'h20, 8'h30};
        burst(q, 1, "bp");

        // illegal headers back-to-back, then single-beat burst
        bad_hdr(8'd0, "ill0");
        bad_hdr(8'd17, "ill17");
        in_valid = 1'b0;
        tick;
        chk("ill_len_err_clear", 32'(len_err), 0);
        chk_idle("ill_idle");
        q = '{8'h55};
        burst(q, 0, "len1");

        // max length then back-to-back short burst
        q = {};
        for (int i = 0; i < MAX_LEN; i++) q.push_back(8'(i));
        burst(q, 0, "max");
        q = '{8'hEE, 8'hFF};
        burst(q, 0, "b2b");

        // reset mid-burst; the beat offered during reset is lost
        put_beat(8'd5, "mid_hdr");
        put_beat(8'h11, "mid_d0");
        put_beat(8'h22, "mid_d1");
        put_beat(8'h33, "mid_d2");
        reset = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h99;
        tick;
        in_valid = 1'b0;
        exp_cnt = 0;
        chk("mid_in_ready", 32'(in_ready), 0);
        chk("mid_out_valid", 32'(out_valid), 0);
        chk("mid_out_data", 32'(out_data), 0);
        chk("mid_out_last", 32'(out_last), 0);
        chk("mid_busy", 32'(busy), 0);
        chk("mid_cnt", 32'(burst_cnt), 0);
        reset = 1'b0;
        tick;
        q = '{8'h01, 8'h02};
        burst(q, 0, "post_rst");

        // randomized bursts and illegal headers under random backpressure
        for (int k = 0; k < 8; k++) begin
            int len = $urandom_range(1, MAX_LEN);
            q = {};
            for (int i = 0; i < len; i++) q.push_back(8'($urandom));
            burst(q, 2, "rand");
            if (k % 3 == 0) begin
                bad_hdr(8'($urandom_range(MAX_LEN + 1, 255)), "rand_ill");
                in_valid = 1'b0;
                tick;
                chk("rand_ill_clear", 32'(len_err), 0);
            end
        end

        // counter wrap
        while (exp_cnt != 0) begin
            q = '{8'($urandom)};
            burst(q, 0, "wrap");
        end
        chk("wrap_cnt_zero", 32'(burst_cnt), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
